bsg_link_upstream_sched: RTL

Credit-based scheduler that shares one `bsg_link_ddr_upstream` core-side input (`core_data_i`/`core_valid_i`/`core_ready_o`) between `num_req_p` requesters. Requesters arbitrate round-robin, and a grant is held for the whole multi-beat packet. A credit counter, refilled by synchronized token pulses, bounds the number of beats in flight toward the downstream link. The block sits in the core clock domain directly in front of the upstream link.

---
 rtl/bsg_link_sched_pkg.sv | 14 +
 rtl/bsg_link_upstream_sched_if.sv | 31 +++
 rtl/bsg_link_upstream_sched_rr_pick.sv | 27 ++
 rtl/bsg_link_upstream_sched.sv | 87 ++++++++
 4 files changed

// File: rtl/bsg_link_sched_pkg.sv
// rtl/bsg_link_sched_pkg.sv - shared types and helpers for the link schedulers
package bsg_link_sched_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Width able to hold every count from 0 to max_credits inclusive.
    function automatic int credit_width(input int max_credits);
        return $clog2(max_credits + 1);
    endfunction

endpackage

// File: rtl/bsg_link_upstream_sched_if.sv
// rtl/bsg_link_upstream_sched_if.sv - requester/link/credit bundle for the upstream scheduler
interface bsg_link_upstream_sched_if #(
    parameter int num_req_p = 4,
    parameter int width_p   = 64,
    parameter int credit_p  = 8
);
    logic [num_req_p-1:0]         req_valid_i;
    logic [num_req_p-1:0]         req_last_i;
    logic [num_req_p*width_p-1:0] req_data_i;
    logic [num_req_p-1:0]         req_ready_o;
    logic                         link_valid_o;
    logic [width_p-1:0]           link_data_o;
    logic                         link_ready_i;
    logic                         token_i;
    logic [bsg_link_sched_pkg::credit_width(credit_p)-1:0] credits_o;
    logic [$clog2(num_req_p)-1:0] grant_o;
    logic                         locked_o;
    logic                         credit_err_o;

    modport master (
        output req_valid_i, req_last_i, req_data_i, link_ready_i, token_i,
        input  req_ready_o, link_valid_o, link_data_o, credits_o, grant_o,
               locked_o, credit_err_o
    );

    modport slave (
        input  req_valid_i, req_last_i, req_data_i, link_ready_i, token_i,
        output req_ready_o, link_valid_o, link_data_o, credits_o, grant_o,
               locked_o, credit_err_o
    );
endinterface

// File: rtl/bsg_link_upstream_sched_rr_pick.sv
// rtl/bsg_link_upstream_sched_rr_pick.sv - combinational round-robin picker (bsg_rr_pick)
module bsg_rr_pick #(
    parameter int n_p = 4
) (
    input  logic [n_p-1:0]         valid,
    input  logic [$clog2(n_p)-1:0] ptr,
    output logic [$clog2(n_p)-1:0] pick,
    output logic                   any
);
    localparam int idx_w = $clog2(n_p);

    logic [idx_w-1:0] idx;

    // Scan from ptr upward with wrap; the first valid entry found wins.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = '0;
        for (int i = 0; i < n_p; i++) begin
            idx = idx_w'((int'(ptr) + i) % n_p);
            if (!any && valid[idx]) begin
                any  = 1'b1;
                pick = idx;
            end
        end
    end
endmodule

// File: rtl/bsg_link_upstream_sched.sv
// rtl/bsg_link_upstream_sched.sv - credit-gated round-robin packet scheduler in front of the upstream link
module bsg_link_upstream_sched
    import bsg_link_sched_pkg::*;
#(
    parameter int num_req_p = 4,
    parameter int width_p   = 64,
    parameter int credit_p  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    bsg_link_upstream_sched_if.slave  bus
);
    localparam int cw = credit_width(credit_p);
    localparam int gw = $clog2(num_req_p);

    state_e        state;
    logic [gw-1:0] rr;
    logic [gw-1:0] grant_q;
    logic [cw-1:0] credits;
    logic          credit_err;

    logic [gw-1:0] pick;
    logic          any;
    logic [gw-1:0] cur;
    logic [gw-1:0] next_rr;
    logic          have_credit;
    logic          link_valid;
    logic          xfer;
    logic          cur_last;

    bsg_rr_pick #(.n_p(num_req_p)) u_pick (
        .valid (bus.req_valid_i),
        .ptr   (rr),
        .pick  (pick),
        .any   (any)
    );

    always_comb begin
        have_credit = (credits != '0);
        cur         = (state == LOCKED) ? grant_q : pick;
        link_valid  = rst && have_credit &&
                      ((state == LOCKED) ? bus.req_valid_i[grant_q] : any);
        xfer        = link_valid && bus.link_ready_i;
        cur_last    = bus.req_last_i[cur];
        next_rr     = (cur == gw'(num_req_p - 1)) ? '0 : cur + 1'b1;
    end

    assign bus.link_valid_o = link_valid;
    assign bus.link_data_o  = link_valid ? bus.req_data_i[int'(cur)*width_p +: width_p] : '0;
    assign bus.req_ready_o  = xfer ? ({{(num_req_p-1){1'b0}}, 1'b1} << cur) : '0;
    // While idle the grant shows the live pick; otherwise the last latched grantee.
    assign bus.grant_o      = (rst && state == IDLE && have_credit && any) ? pick : grant_q;
    assign bus.credits_o    = credits;
    assign bus.locked_o     = (state == LOCKED);
    assign bus.credit_err_o = credit_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            rr         <= '0;
            grant_q    <= '0;
            credits    <= cw'(credit_p);
            credit_err <= 1'b0;
        end else begin
            if (xfer && !bus.token_i) begin
                credits <= credits - 1'b1;
            end else if (bus.token_i && !xfer) begin
                // A token beyond the full count means the far side lost track.
                if (credits == cw'(credit_p)) begin
                    credit_err <= 1'b1;
                end else begin
                    credits <= credits + 1'b1;
                end
            end

            if (xfer) begin
                grant_q <= cur;
                if (cur_last) begin
                    state <= IDLE;
                    rr    <= next_rr;
                end else begin
                    state <= LOCKED;
                end
            end
        end
    end
endmodule
